// File: rtl/cond_sum_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cond_sum_pipe: two-stage pipelined conditional-sum adder/subtractor.     |
// | Optional OVF/ZERO flag outputs enabled by macro COND_SUM_PIPE_FLAGS_EN.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cond_sum_pipe #(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             COUT
`ifdef COND_SUM_PIPE_FLAGS_EN
  ,
  output logic             OVF,
  output logic             ZERO
`endif
);

  localparam int NSEG = WIDTH / SEG;

  if ((WIDTH % SEG) != 0 || SEG < 2) begin : g_param_check
    $error("cond_sum_pipe: WIDTH must be a multiple of SEG and SEG must be >= 2");
  end

  logic [WIDTH-1:0] beff;
  logic             c0;
  logic             adv1;
  logic             adv2;
  logic             s1_valid;
  logic [WIDTH-1:0] n_sum0;
  logic [WIDTH-1:0] n_sum1;
  logic [NSEG-1:0]  n_co0;
  logic [NSEG-1:0]  n_co1;
  logic [WIDTH-1:0] s1_sum0;
  logic [WIDTH-1:0] s1_sum1;
  logic [NSEG-1:0]  s1_co0;
  logic [NSEG-1:0]  s1_co1;
  logic [NSEG:0]    c;
  logic [WIDTH-1:0] sel_sum;

  assign beff     = SUB ? ~B : B;
  assign c0       = SUB | CIN;
  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  // Segment 0 already holds its true result in both slots, so c[0] is a dummy.
  assign c[0] = 1'b0;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    logic [SEG:0] t0;
    logic [SEG:0] t1;
    if (k == 0) begin : g_lsb
      assign t0 = {1'b0, A[SEG-1:0]} + {1'b0, beff[SEG-1:0]} + {{SEG{1'b0}}, c0};
      assign t1 = t0;
    end else begin : g_upper
      assign t0 = {1'b0, A[k*SEG +: SEG]} + {1'b0, beff[k*SEG +: SEG]};
      assign t1 = {1'b0, A[k*SEG +: SEG]} + {1'b0, beff[k*SEG +: SEG]} + {{SEG{1'b0}}, 1'b1};
    end
    assign n_sum0[k*SEG +: SEG] = t0[SEG-1:0];
    assign n_sum1[k*SEG +: SEG] = t1[SEG-1:0];
    assign n_co0[k]             = t0[SEG];
    assign n_co1[k]             = t1[SEG];

    assign c[k+1]                = c[k] ? s1_co1[k] : s1_co0[k];
    assign sel_sum[k*SEG +: SEG] = c[k] ? s1_sum1[k*SEG +: SEG] : s1_sum0[k*SEG +: SEG];
  end

`ifdef COND_SUM_PIPE_FLAGS_EN
  // Operand MSBs are kept so stage 2 can recover the carry into the MSB.
  logic s1_a_msb;
  logic s1_b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
    end else if (adv1 && in_valid) begin
      s1_a_msb <= A[WIDTH-1];
      s1_b_msb <= beff[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OVF  <= 1'b0;
      ZERO <= 1'b0;
    end else if (adv2 && s1_valid) begin
      OVF  <= c[NSEG] ^ (sel_sum[WIDTH-1] ^ s1_a_msb ^ s1_b_msb);
      ZERO <= (sel_sum == '0);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum0  <= '0;
      s1_sum1  <= '0;
      s1_co0   <= '0;
      s1_co1   <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum0 <= n_sum0;
        s1_sum1 <= n_sum1;
        s1_co0  <= n_co0;
        s1_co1  <= n_co1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      S         <= '0;
      COUT      <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        S    <= sel_sum;
        COUT <= c[NSEG];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cond_sum_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cond_sum_pipe: directed and random self-checking bench for            |
// | cond_sum_pipe (main 64/16 instance plus 8/2, 32/32, 96/32 instances).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cond_sum_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] s;
  logic        cout;
`ifdef COND_SUM_PIPE_FLAGS_EN
  logic        ovf;
  logic        zero;
`endif
  logic        main_done;

  int n_vec;
  int n_fail;

  cond_sum_pipe #(.WIDTH(64), .SEG(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .CIN(cin), .SUB(sub),
    .out_valid(out_valid), .out_ready(out_ready), .S(s), .COUT(cout)
`ifdef COND_SUM_PIPE_FLAGS_EN
    , .OVF(ovf), .ZERO(zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [64:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic ci, input logic sb);
    logic [63:0] ye;
    ye = sb ? ~y : y;
    return {1'b0, x} + {1'b0, ye} + {64'd0, sb | ci};
  endfunction

  task automatic do_op(input string tag, input logic [63:0] xa, input logic [63:0] xb,
                       input logic ci, input logic sb, input logic [63:0] es,
                       input logic ec, input logic eovf, input logic ezero);
    @(negedge clk);
    a = xa; b = xb; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1"}, 128'(out_valid), 128'(1'b0));
    @(negedge clk);
    check({tag, "_lat2"}, 128'(out_valid), 128'(1'b1));
    check({tag, "_s"}, 128'(s), 128'(es));
    check({tag, "_cout"}, 128'(cout), 128'(ec));
`ifdef COND_SUM_PIPE_FLAGS_EN
    check({tag, "_ovf"}, 128'(ovf), 128'(eovf));
    check({tag, "_zero"}, 128'(zero), 128'(ezero));
`else
    if (eovf || ezero) begin end
`endif
  endtask

  // Parameter sweep instances; each streams 1000 random ops once the main tests finish.
  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int W  = (gi == 0) ? 8 : (gi == 1) ? 32 : 96;
    localparam int SG = (gi == 0) ? 2 : 32;
    logic         iv;
    logic         ir;
    logic         ov;
    logic         ordy;
    logic         ci;
    logic         sb;
    logic         co;
    logic [W-1:0] sa;
    logic [W-1:0] sbv;
    logic [W-1:0] ss;
    logic         done;
    logic [W:0]   q[$];
`ifdef COND_SUM_PIPE_FLAGS_EN
    logic         of;
    logic         zf;
`endif

    cond_sum_pipe #(.WIDTH(W), .SEG(SG)) u_sw (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
      .A(sa), .B(sbv), .CIN(ci), .SUB(sb),
      .out_valid(ov), .out_ready(ordy), .S(ss), .COUT(co)
`ifdef COND_SUM_PIPE_FLAGS_EN
      , .OVF(of), .ZERO(zf)
`endif
    );

    initial begin
      logic [95:0]  r;
      logic [31:0]  rc;
      logic [W-1:0] be;
      logic [W:0]   ev;
      done = 1'b0; iv = 1'b0; ordy = 1'b1; ci = 1'b0; sb = 1'b0;
      sa = '0; sbv = '0;
      wait (main_done);
      for (int n = 0; n < 1003; n++) begin
        @(negedge clk);
        if (ov) begin
          if (q.size() == 0) check($sformatf("sweep%0d_extra", W), 128'(1), 128'(0));
          else check($sformatf("sweep%0d_res", W), 128'({co, ss}), 128'(q.pop_front()));
        end
        if (n < 1000) begin
          r   = {$urandom(), $urandom(), $urandom()};
          sa  = r[W-1:0];
          r   = {$urandom(), $urandom(), $urandom()};
          sbv = r[W-1:0];
          rc  = $urandom();
          ci  = rc[0];
          sb  = rc[1];
          be  = sb ? ~sbv : sbv;
          ev  = {1'b0, sa} + {1'b0, be} + {{W{1'b0}}, sb | ci};
          q.push_back(ev);
          iv  = 1'b1;
        end else begin
          iv = 1'b0;
        end
      end
      check($sformatf("sweep%0d_drain", W), 128'(q.size()), 128'(0));
      done = 1'b1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] op_a[10];
    logic [63:0] op_b[10];
    logic        op_c[10];
    logic        op_s[10];
    logic [64:0] bq[$];
    logic [63:0] hold_s;
    logic [31:0] rc;
    int          sent;
    int          rcvd;
    int          last_acc;
    int          last_rcv;

    n_vec = 0; n_fail = 0; main_done = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; hold_s = '0;

    repeat (2) @(negedge clk);
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_s", 128'(s), 128'(0));
    check("rst_cout", 128'(cout), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_inready", 128'(in_ready), 128'(1));

    do_op("carry_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    do_op("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    do_op("sub_pos", 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0, 1'b0);
    do_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0,
          64'h8000_0000_0000_0001, 1'b0, 1'b1, 1'b0);
    do_op("sub_cin_ign", 64'h1_0000, 64'h1, 1'b0, 1'b1, 64'hFFFF, 1'b1, 1'b0, 1'b0);

    // Backpressure: 10 back-to-back ops, consumer stalled for the first 5 cycles.
    for (int i = 0; i < 10; i++) begin
      op_a[i] = {$urandom(), $urandom()};
      op_b[i] = {$urandom(), $urandom()};
      rc      = $urandom();
      op_c[i] = rc[0];
      op_s[i] = rc[1];
    end
    sent = 0; rcvd = 0; last_acc = -1; last_rcv = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      #1;
      if (out_valid && out_ready) begin
        if (bq.size() == 0) check("bp_dup", 128'(1), 128'(0));
        else check("bp_res", 128'({cout, s}), 128'(bq.pop_front()));
        rcvd++;
        last_rcv = cyc;
      end
      if (cyc == 2) begin
        check("bp_inready_low", 128'(in_ready), 128'(0));
        check("bp_held_cnt", 128'(sent), 128'(2));
        hold_s = s;
      end
      if (cyc == 3 || cyc == 4) check("bp_stable", 128'(s), 128'(hold_s));
      if (sent < 10) begin
        a = op_a[sent]; b = op_b[sent]; cin = op_c[sent]; sub = op_s[sent];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) begin
        bq.push_back(ref_add(op_a[sent], op_b[sent], op_c[sent], op_s[sent]));
        sent++;
        last_acc = cyc;
      end
    end
    check("bp_sent", 128'(sent), 128'(10));
    check("bp_rcvd", 128'(rcvd), 128'(10));
    check("bp_last_acc", 128'(last_acc), 128'(12));
    check("bp_last_rcv", 128'(last_rcv), 128'(14));

    // Async reset with two operations held in the pipe.
    @(negedge clk);
    out_ready = 1'b0;
    a = 64'd1; b = 64'd2; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 64'd3; b = 64'd4;
    @(negedge clk);
    in_valid = 1'b0;
    check("ar_pre_s", 128'(s), 128'(3));
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 128'(out_valid), 128'(0));
    check("ar_s", 128'(s), 128'(0));
    check("ar_cout", 128'(cout), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ar_no_stale", 128'(out_valid), 128'(0));
      check("ar_inready", 128'(in_ready), 128'(1));
    end

    main_done = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) break;
      @(negedge clk);
    end
    check("sweep_done", 128'({g_sweep[0].done, g_sweep[1].done, g_sweep[2].done}), 128'(3'b111));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
